bcp_implication_dispatcher: RTL and testbench

- Consumer end of the BCP result FIFO. It pops unit-clause bitmask words pushed by the BCP engine and serialises every set bit into an indexed implication request for the assignment unit.
- Uses a valid/ready handshake. Honours a conflict abort by flushing the FIFO.
- Sits between the result FIFO output and the assignment/trail logic.

---
 rtl/bcp_implication_dispatcher_if.sv | 33 +++
 rtl/bcp_implication_dispatcher.sv | 111 +++++++++++
 tb/tb_bcp_implication_dispatcher.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcp_implication_dispatcher_if.sv
// Port bundle between the BCP implication dispatcher, the result FIFO and the assignment unit.
// Handshake: an implication transfers on a rising clock edge where imp_valid && imp_ready;
// imp_valid is never withdrawn and imp_clause never changes until that transfer happens.
interface bcp_implication_dispatcher_if #(
    parameter int data_width = 32,
    parameter int idx_width  = 8
);
    logic                  dispatch_en;
    logic                  fifo_empty;
    logic [data_width-1:0] fifo_dataout;
    logic                  fifo_read;
    logic                  conflict;
    logic                  imp_valid;
    logic                  imp_ready;
    logic [idx_width-1:0]  imp_clause;
    logic [7:0]            imp_count;
    logic                  dispatch_busy;
    logic                  dispatch_done;
    logic                  aborted;
    logic [2:0]            dbg_state;

    modport master (
        input  dispatch_en, fifo_empty, fifo_dataout, conflict, imp_ready,
        output fifo_read, imp_valid, imp_clause, imp_count,
               dispatch_busy, dispatch_done, aborted, dbg_state
    );

    modport slave (
        output dispatch_en, fifo_empty, fifo_dataout, conflict, imp_ready,
        input  fifo_read, imp_valid, imp_clause, imp_count,
               dispatch_busy, dispatch_done, aborted, dbg_state
    );
endinterface

// File: rtl/bcp_implication_dispatcher.sv
// Pops unit-clause bitmask words from the BCP result FIFO and issues one indexed
// implication request per set bit, lowest index first; a conflict drains the FIFO.
module bcp_implication_dispatcher #(
    parameter int clause_num = 8,
    parameter int data_width = 32,
    parameter int idx_width  = 8
) (
    input logic clock,
    input logic reset,
    bcp_implication_dispatcher_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_SCAN  = 3'd3,
        S_ISSUE = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [clause_num-1:0]  mask_q, mask_d;
    logic [idx_width-1:0]   clause_q;
    logic [7:0]             count_q;
    logic                   read_q;
    logic                   done_q;
    logic                   aborted_q;
    logic [idx_width-1:0]   low_idx;
    logic                   handshake;
    logic                   abortable;
    logic                   unused_dataout;

    assign unused_dataout = ^bus.fifo_dataout;
    assign handshake      = (state_q == S_ISSUE) && bus.imp_ready;
    assign abortable      = (state_q == S_POP) || (state_q == S_LOAD) ||
                            (state_q == S_SCAN) || (state_q == S_ISSUE);

    always_comb begin
        low_idx = '0;
        for (int i = clause_num - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = idx_width'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE:  if (bus.dispatch_en) state_d = bus.fifo_empty ? S_DONE : S_POP;
            S_POP:   state_d = S_LOAD;
            S_LOAD: begin
                mask_d  = bus.fifo_dataout[clause_num-1:0];
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (mask_q == '0) state_d = bus.fifo_empty ? S_DONE : S_POP;
                else              state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (handshake) begin
                    mask_d  = mask_q & ~(clause_num'(1) << clause_q);
                    state_d = S_SCAN;
                end
            end
            S_FLUSH: if (bus.fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over every other transition; a simultaneous handshake is still counted below.
        if (bus.conflict && abortable) begin
            state_d = S_FLUSH;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            clause_q  <= '0;
            count_q   <= '0;
            read_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            // Flush reads lag the empty flag by a cycle, so one harmless read may hit an empty FIFO.
            read_q  <= (state_d == S_POP) ||
                       ((state_q == S_FLUSH) && (state_d == S_FLUSH) && !bus.fifo_empty);
            done_q  <= (state_q == S_DONE);
            if ((state_q == S_IDLE) && bus.dispatch_en) begin
                count_q   <= '0;
                aborted_q <= 1'b0;
            end
            if ((state_q == S_SCAN) && (state_d == S_ISSUE)) clause_q <= low_idx;
            if (handshake && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
            if (state_q == S_FLUSH) aborted_q <= 1'b1;
        end
    end

    assign bus.fifo_read     = read_q;
    assign bus.imp_valid     = (state_q == S_ISSUE);
    assign bus.imp_clause    = clause_q;
    assign bus.imp_count     = count_q;
    assign bus.dispatch_busy = (state_q != S_IDLE);
    assign bus.dispatch_done = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_bcp_implication_dispatcher.sv
// Bench for bcp_implication_dispatcher: a FIFO model serviced every cycle, scenario tasks
// and a reference model that expands queued words into the expected clause-index stream.
module tb_bcp_implication_dispatcher;
    localparam int W = 8;

    logic clock;
    logic reset;

    bcp_implication_dispatcher_if #(.data_width(32), .idx_width(W)) bus ();

    bcp_implication_dispatcher #(.clause_num(8), .data_width(32), .idx_width(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    logic [31:0]  fifo_q[$];
    logic [31:0]  words_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           hs_cyc_q[$];
    int           exp_count;
    int           rd_pulses;
    int           first_lat;
    int           done_lat;
    int           done_pulses;
    bit           timed_out;
    bit           unstable;

    // FIFO model: a read seen at an edge pops the head onto fifo_dataout just after it.
    task automatic tick();
        logic rd;
        rd = bus.fifo_read;
        @(posedge clock);
        #1;
        if (rd) begin
            rd_pulses++;
            if (fifo_q.size() > 0) bus.fifo_dataout = fifo_q.pop_front();
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        words_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // Reference model: every set bit of the low byte, ascending, word by word.
    task automatic build_exp();
        exp_q.delete();
        foreach (words_q[k]) begin
            for (int i = 0; i < 8; i++) begin
                if (words_q[k][i]) exp_q.push_back(W'(i));
            end
        end
        exp_count = (exp_q.size() > 255) ? 255 : exp_q.size();
    endtask

    // Starts one run and services the handshake until dispatch_done or the cycle budget.
    task automatic run(input int max_cyc, input int hold_low, input int ready_pct, input int conflict_at);
        int           cyc;
        int           issues;
        int           valid_seen;
        bit           prev_stall;
        logic [W-1:0] prev_clause;
        cyc = 0; issues = 0; valid_seen = 0; prev_stall = 0; prev_clause = '0;
        got_q.delete(); hs_cyc_q.delete();
        rd_pulses = 0; first_lat = -1; done_lat = -1; done_pulses = 0; timed_out = 0; unstable = 0;
        bus.dispatch_en = 1'b1;
        while (done_lat < 0 && cyc < max_cyc) begin
            bus.conflict  = 1'b0;
            bus.imp_ready = 1'b0;
            if (bus.imp_valid) begin
                if (prev_stall && bus.imp_clause !== prev_clause) unstable = 1;
                if (valid_seen >= hold_low) bus.imp_ready = ($urandom_range(99) < ready_pct);
                if (conflict_at == issues) begin
                    bus.conflict  = 1'b1;
                    bus.imp_ready = 1'b1;
                end
                valid_seen++;
                if (bus.imp_ready) begin
                    got_q.push_back(bus.imp_clause);
                    hs_cyc_q.push_back(cyc);
                    issues++;
                end
                prev_stall  = !bus.imp_ready;
                prev_clause = bus.imp_clause;
            end else begin
                if (prev_stall) unstable = 1;
                prev_stall = 0;
            end
            tick();
            cyc++;
            bus.dispatch_en = 1'b0;
            if (first_lat < 0 && bus.imp_valid) first_lat = cyc;
            if (bus.dispatch_done) begin
                done_lat = cyc;
                done_pulses++;
            end
        end
        timed_out     = (done_lat < 0);
        bus.imp_ready = 1'b0;
        bus.conflict  = 1'b0;
        repeat (3) begin
            tick();
            if (bus.dispatch_done) done_pulses++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (bus.imp_valid !== 1'b0) begin errors++; $display("FAIL reset_imp_valid got %0b exp 0", bus.imp_valid); end
        checks++; if (bus.fifo_read !== 1'b0) begin errors++; $display("FAIL reset_fifo_read got %0b exp 0", bus.fifo_read); end
        checks++; if (bus.dispatch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.dispatch_busy); end
        checks++; if (bus.dispatch_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.dispatch_done); end
        checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %0b exp 0", bus.aborted); end
        checks++; if (bus.imp_count !== 8'd0 || bus.imp_clause !== '0) begin errors++; $display("FAIL reset_count_clause got %0d/%0d exp 0/0", bus.imp_count, bus.imp_clause); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        words_q.delete();
        push_word(32'h0000_0025);
        build_exp();
        run(100, 0, 100, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL single_timeout got no done exp done"); end
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL single_sequence got %p exp %p", got_q, exp_q); end
        checks++; if (first_lat != 4) begin errors++; $display("FAIL single_first_latency got %0d exp 4", first_lat); end
        checks++; if (hs_cyc_q.size() != 3 || hs_cyc_q[1] - hs_cyc_q[0] != 2 || hs_cyc_q[2] - hs_cyc_q[1] != 2) begin
            errors++; $display("FAIL single_spacing got %p exp steps of 2", hs_cyc_q); end
        checks++; if (bus.imp_count !== 8'(exp_count)) begin errors++; $display("FAIL single_count got %0d exp %0d", bus.imp_count, exp_count); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL single_done_pulses got %0d exp 1", done_pulses); end
        checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL single_aborted got %0b exp 0", bus.aborted); end
    endtask

    task automatic test_backpressure();
        words_q.delete();
        push_word(32'h0000_0081);
        build_exp();
        run(100, 5, 100, -1);
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL bp_sequence got %p exp %p", got_q, exp_q); end
        checks++; if (unstable) begin errors++; $display("FAIL bp_stable got unstable=1 exp 0"); end
        checks++; if (bus.imp_count !== 8'(exp_count)) begin errors++; $display("FAIL bp_count got %0d exp %0d", bus.imp_count, exp_count); end
    endtask

    task automatic test_multi_word();
        words_q.delete();
        push_word(32'h0000_0003);
        push_word(32'h0000_0000);
        push_word(32'h0000_0080);
        build_exp();
        run(200, 0, 100, -1);
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL multi_sequence got %p exp %p", got_q, exp_q); end
        checks++; if (rd_pulses != 3) begin errors++; $display("FAIL multi_reads got %0d exp 3", rd_pulses); end
        checks++; if (bus.imp_count !== 8'(exp_count)) begin errors++; $display("FAIL multi_count got %0d exp %0d", bus.imp_count, exp_count); end
    endtask

    task automatic test_empty_start();
        words_q.delete();
        run(20, 0, 100, -1);
        checks++; if (done_lat != 2) begin errors++; $display("FAIL empty_done_latency got %0d exp 2", done_lat); end
        checks++; if (rd_pulses != 0) begin errors++; $display("FAIL empty_reads got %0d exp 0", rd_pulses); end
        checks++; if (bus.imp_count !== 8'd0 || got_q.size() != 0) begin errors++; $display("FAIL empty_count got %0d exp 0", bus.imp_count); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL empty_done_pulses got %0d exp 1", done_pulses); end
    endtask

    task automatic test_conflict();
        logic [31:0] w;
        words_q.delete();
        for (int k = 0; k < 3; k++) begin
            w = $urandom();
            if (k == 0) w[7:0] = w[7:0] | 8'h10;
            push_word(w);
        end
        build_exp();
        run(200, 0, 100, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL conflict_timeout got no done exp done"); end
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL conflict_issued got %p exp %0d", got_q, exp_q[0]); end
        checks++; if (bus.imp_count !== 8'd1) begin errors++; $display("FAIL conflict_count got %0d exp 1", bus.imp_count); end
        checks++; if (fifo_q.size() != 0 || bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL conflict_drain got %0d left exp 0", fifo_q.size()); end
        checks++; if (bus.aborted !== 1'b1) begin errors++; $display("FAIL conflict_aborted got %0b exp 1", bus.aborted); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL conflict_done_pulses got %0d exp 1", done_pulses); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int          n;
        int          pct;
        for (int r = 0; r < 6; r++) begin
            words_q.delete();
            n = $urandom_range(4, 1);
            for (int k = 0; k < n; k++) begin
                w = $urandom();
                if ($urandom_range(3) == 0) w[7:0] = 8'h00;
                push_word(w);
            end
            build_exp();
            pct = $urandom_range(100, 30);
            run(1000, 0, pct, -1);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout got no done exp done", r); end
            checks++; if (got_q != exp_q) begin errors++; $display("FAIL rand%0d_sequence got %p exp %p", r, got_q, exp_q); end
            checks++; if (bus.imp_count !== 8'(exp_count)) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", r, bus.imp_count, exp_count); end
            checks++; if (rd_pulses != n) begin errors++; $display("FAIL rand%0d_reads got %0d exp %0d", r, rd_pulses, n); end
            checks++; if (bus.aborted !== 1'b0 || done_pulses != 1) begin errors++; $display("FAIL rand%0d_end got aborted=%0b done=%0d exp 0/1", r, bus.aborted, done_pulses); end
        end
    endtask

    task automatic test_saturation();
        words_q.delete();
        for (int k = 0; k < 33; k++) push_word(32'hABCD_00FF);
        build_exp();
        run(3000, 0, 100, -1);
        checks++; if (got_q.size() != 264) begin errors++; $display("FAIL sat_issued got %0d exp 264", got_q.size()); end
        checks++; if (bus.imp_count !== 8'(exp_count)) begin errors++; $display("FAIL sat_count got %0d exp %0d", bus.imp_count, exp_count); end
    endtask

    task automatic test_reset_mid_run();
        int  guard;
        bit  seen;
        words_q.delete();
        push_word(32'h0000_0081);
        push_word(32'h0000_000F);
        rd_pulses = 0;
        bus.dispatch_en = 1'b1;
        tick();
        bus.dispatch_en = 1'b0;
        for (int phase = 0; phase < 2; phase++) begin
            seen = 0;
            guard = 0;
            while (!seen && guard < 20) begin
                if (bus.imp_valid) seen = 1;
                else begin tick(); guard++; end
            end
            checks++; if (!seen) begin errors++; $display("FAIL midrst_valid%0d got 0 exp 1", phase); end
            if (phase == 0) begin
                bus.imp_ready = 1'b1;
                tick();
                bus.imp_ready = 1'b0;
            end
        end
        reset = 1'b1;
        #1;
        checks++; if (bus.imp_valid !== 1'b0 || bus.dispatch_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got valid=%0b busy=%0b exp 0/0", bus.imp_valid, bus.dispatch_busy); end
        checks++; if (bus.imp_count !== 8'd0 || bus.imp_clause !== '0) begin errors++; $display("FAIL midrst_regs got %0d/%0d exp 0/0", bus.imp_count, bus.imp_clause); end
        checks++; if (bus.fifo_read !== 1'b0 || bus.aborted !== 1'b0 || bus.dispatch_done !== 1'b0) begin errors++; $display("FAIL midrst_flags got rd=%0b ab=%0b dn=%0b exp 0", bus.fifo_read, bus.aborted, bus.dispatch_done); end
        tick();
        reset = 1'b0;
        rd_pulses = 0;
        repeat (8) tick();
        checks++; if (rd_pulses != 0 || bus.imp_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet got reads=%0d valid=%0b exp 0/0", rd_pulses, bus.imp_valid); end
        fifo_q.delete();
        bus.fifo_empty = 1'b1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.dispatch_en  = 1'b0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_dataout = '0;
        bus.conflict     = 1'b0;
        bus.imp_ready    = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_multi_word();
        test_empty_start();
        test_conflict();
        test_random();
        test_saturation();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
